// File: rtl/bc_referee.sv
// Bulls & Cows scorer: one guess per write_frame/frame_written handshake, scored 8 edges after acceptance.
// Ack stays high until write_frame drops; a finished game acks on the next edge with no update.
module bc_referee #(
    parameter int unsigned MAX_ATTEMPTS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] secret_in,
    input  logic [3:0]  guessed_number_0,
    input  logic [3:0]  guessed_number_1,
    input  logic [3:0]  guessed_number_2,
    input  logic [3:0]  guessed_number_3,
    input  logic        write_frame,
    output logic        frame_written,
    output logic [2:0]  bulls,
    output logic [2:0]  cows,
    output logic [7:0]  attempts,
    output logic        secret_valid,
    output logic        win,
    output logic        game_over
);
    typedef enum logic [1:0] {IDLE, BULL, COW, ACK} state_t;

    state_t      state, state_nxt;
    logic [3:0]  g [4];
    logic [3:0]  s [4];
    logic [1:0]  idx;
    logic [3:0]  bm, um;
    logic [2:0]  bull_cnt, cow_cnt;

    logic        do_load, do_start, last_digit;
    logic        bull_hit, cow_found, cow_hit;
    logic [1:0]  cow_j;
    logic [2:0]  cow_final;
    logic [7:0]  att_inc;
    logic        new_win, limit_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        do_load    = 1'b0;
        do_start   = 1'b0;
        last_digit = (idx == 2'd3);
        case (state)
            IDLE: begin
                if (load) begin
                    do_load = 1'b1;
                end else if (write_frame && secret_valid && !game_over) begin
                    do_start  = 1'b1;
                    state_nxt = BULL;
                end else if (write_frame && game_over) begin
                    state_nxt = ACK;
                end
            end
            BULL:    if (last_digit) state_nxt = COW;
            COW:     if (last_digit) state_nxt = ACK;
            ACK:     if (!write_frame) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A cow matches the lowest secret position that is neither a bull nor already claimed.
    always_comb begin
        bull_hit  = (g[idx] == s[idx]);
        cow_found = 1'b0;
        cow_j     = 2'd0;
        for (int j = 0; j < 4; j++) begin
            if (!cow_found && !bm[j] && !um[j] && (s[j] == g[idx])) begin
                cow_found = 1'b1;
                cow_j     = 2'(j);
            end
        end
        cow_hit   = !bm[idx] && cow_found;
        cow_final = cow_cnt + {2'b00, cow_hit};
        att_inc   = (attempts == 8'hFF) ? attempts : attempts + 8'd1;
        new_win   = (bull_cnt == 3'd4);
        limit_hit = (MAX_ATTEMPTS != 0) && (32'(att_inc) == MAX_ATTEMPTS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                g[k] <= 4'd0;
                s[k] <= 4'd0;
            end
            idx           <= 2'd0;
            bm            <= 4'd0;
            um            <= 4'd0;
            bull_cnt      <= 3'd0;
            cow_cnt       <= 3'd0;
            frame_written <= 1'b0;
            bulls         <= 3'd0;
            cows          <= 3'd0;
            attempts      <= 8'd0;
            secret_valid  <= 1'b0;
            win           <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (do_load) begin
                        s[0]         <= secret_in[3:0];
                        s[1]         <= secret_in[7:4];
                        s[2]         <= secret_in[11:8];
                        s[3]         <= secret_in[15:12];
                        secret_valid <= 1'b1;
                        attempts     <= 8'd0;
                        bulls        <= 3'd0;
                        cows         <= 3'd0;
                        win          <= 1'b0;
                        game_over    <= 1'b0;
                    end else if (do_start) begin
                        g[0]     <= guessed_number_0;
                        g[1]     <= guessed_number_1;
                        g[2]     <= guessed_number_2;
                        g[3]     <= guessed_number_3;
                        idx      <= 2'd0;
                        bm       <= 4'd0;
                        um       <= 4'd0;
                        bull_cnt <= 3'd0;
                        cow_cnt  <= 3'd0;
                    end
                end
                BULL: begin
                    if (bull_hit) begin
                        bm[idx]  <= 1'b1;
                        bull_cnt <= bull_cnt + 3'd1;
                    end
                    idx <= idx + 2'd1;
                end
                COW: begin
                    if (cow_hit) um[cow_j] <= 1'b1;
                    cow_cnt <= cow_final;
                    idx     <= idx + 2'd1;
                    if (last_digit) begin
                        bulls         <= bull_cnt;
                        cows          <= cow_final;
                        attempts      <= att_inc;
                        win           <= new_win;
                        game_over     <= new_win | limit_hit;
                        frame_written <= 1'b1;
                    end
                end
                ACK:     frame_written <= write_frame;
                default: frame_written <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_bc_referee.sv
// Directed, table-driven bench for bc_referee built with a 3-guess attempt limit.
module tb_bc_referee;
    logic        clk = 1'b0;
    logic        rst, load, write_frame;
    logic [15:0] secret_in, guess;
    logic        frame_written, secret_valid, win, game_over;
    logic [2:0]  bulls, cows;
    logic [7:0]  attempts;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    bc_referee #(.MAX_ATTEMPTS(3)) dut (
        .clk              (clk),
        .rst              (rst),
        .load             (load),
        .secret_in        (secret_in),
        .guessed_number_0 (guess[3:0]),
        .guessed_number_1 (guess[7:4]),
        .guessed_number_2 (guess[11:8]),
        .guessed_number_3 (guess[15:12]),
        .write_frame      (write_frame),
        .frame_written    (frame_written),
        .bulls            (bulls),
        .cows             (cows),
        .attempts         (attempts),
        .secret_valid     (secret_valid),
        .win              (win),
        .game_over        (game_over)
    );

    typedef struct {
        logic        do_load;
        logic [15:0] secret;
        logic [15:0] guess;
        int          bulls, cows, attempts, win, game_over;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] sec);
        @(negedge clk);
        load      = 1'b1;
        secret_in = sec;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Issues one request at a negedge, measures edges from acceptance to ack, then
    // releases write_frame one cycle after seeing the ack (solver behaviour).
    task automatic score(input string nm, input logic [15:0] g, input logic [15:0] g_alt,
                         input int exp_lat);
        int  cnt;
        logic got;
        cnt   = 0;
        got   = 1'b0;
        guess = g;
        write_frame = 1'b1;
        while (cnt < 40 && !got) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (cnt == 1) guess = g_alt;
            if (frame_written) got = 1'b1;
        end
        check({nm, " latency"}, cnt - 1, exp_lat);
        @(posedge clk);
        @(negedge clk);
        check({nm, " ack 2nd cycle"}, frame_written, 1);
        write_frame = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({nm, " ack drop"}, frame_written, 0);
    endtask

    initial begin
        int highs;
        rst = 1'b1; load = 1'b0; write_frame = 1'b0; secret_in = 16'h0; guess = 16'h0;

        // digit 0 lives in the low nibble, so secret 1,2,3,4 is 16'h4321
        tbl[0] = '{1'b1, 16'h4321, 16'h4321, 4, 0, 1, 1, 1};
        tbl[1] = '{1'b1, 16'h4321, 16'h1234, 0, 4, 1, 0, 0};
        tbl[2] = '{1'b0, 16'h0000, 16'h3421, 2, 2, 2, 0, 0};
        tbl[3] = '{1'b1, 16'h3211, 16'h1111, 2, 0, 1, 0, 0};
        tbl[4] = '{1'b0, 16'h0000, 16'h0112, 1, 2, 2, 0, 0};
        tbl[5] = '{1'b0, 16'h0000, 16'h1111, 2, 0, 3, 0, 1};
        tbl[6] = '{1'b1, 16'h0000, 16'h5550, 1, 0, 1, 0, 0};
        tbl[7] = '{1'b0, 16'h0000, 16'h0000, 4, 0, 2, 1, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset fw", frame_written, 0);
        check("reset bulls", bulls, 0);
        check("reset cows", cows, 0);
        check("reset attempts", attempts, 0);
        check("reset secret_valid", secret_valid, 0);
        check("reset win", win, 0);
        check("reset game_over", game_over, 0);

        // Requests before any load must be ignored.
        highs = 0;
        write_frame = 1'b1;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_written) highs++;
        end
        write_frame = 1'b0;
        check("no-secret ack cycles", highs, 0);

        for (int v = 0; v < 8; v++) begin
            if (tbl[v].do_load) begin
                do_load(tbl[v].secret);
                check($sformatf("v%0d secret_valid", v), secret_valid, 1);
            end
            score($sformatf("v%0d", v), tbl[v].guess, tbl[v].guess, 8);
            check($sformatf("v%0d bulls", v), bulls, tbl[v].bulls);
            check($sformatf("v%0d cows", v), cows, tbl[v].cows);
            check($sformatf("v%0d attempts", v), attempts, tbl[v].attempts);
            check($sformatf("v%0d win", v), win, tbl[v].win);
            check($sformatf("v%0d game_over", v), game_over, tbl[v].game_over);
        end

        // Game is over: next request acks after one edge and changes nothing.
        score("over", 16'h1234, 16'h1234, 1);
        check("over bulls", bulls, 4);
        check("over attempts", attempts, 2);

        // Holding write_frame keeps the ack up.
        write_frame = 1'b1;
        @(posedge clk);
        @(negedge clk);
        highs = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_written) highs++;
        end
        check("hold ack cycles", highs, 6);
        write_frame = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold ack drop", frame_written, 0);

        // Load clears the game state.
        do_load(16'h4321);
        check("reload attempts", attempts, 0);
        check("reload win", win, 0);
        check("reload game_over", game_over, 0);
        check("reload bulls", bulls, 0);

        // Guess inputs changed after acceptance must not matter.
        score("late change", 16'h4321, 16'h1234, 8);
        check("late change bulls", bulls, 4);
        check("late change cows", cows, 0);

        // Reset sampled at edge N+5 aborts the score.
        do_load(16'h4321);
        guess = 16'h1234;
        write_frame = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        write_frame = 1'b0;
        check("midrst fw", frame_written, 0);
        check("midrst bulls", bulls, 0);
        check("midrst cows", cows, 0);
        check("midrst attempts", attempts, 0);
        check("midrst secret_valid", secret_valid, 0);
        check("midrst game_over", game_over, 0);
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (frame_written) highs++;
        end
        check("midrst no late ack", highs, 6);
        do_load(16'h4321);
        score("post rst", 16'h4321, 16'h4321, 8);
        check("post rst bulls", bulls, 4);
        check("post rst attempts", attempts, 1);
        check("post rst win", win, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/bc_referee.md
# bc_referee

Scoring stage for the Bulls & Cows game, downstream of the guess solver. It holds the secret 4-digit code and accepts one guess per `write_frame` / `frame_written` handshake. For each guess it computes bulls and cows sequentially, keeps an attempt count and flags win or game over. Its `bulls` output drives the solver's `bulls` input directly.

## Interface
- MAX_ATTEMPTS, default 16: attempt limit; `game_over` is set when `attempts` reaches this value. 0 means unlimited.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures `secret_in`. Accepted only in IDLE.
- secret_in  in  16  secret digits; [3:0] is digit 0 … [15:12] is digit 3. Each digit is 0..15 and duplicates are allowed.
- guessed_number_0..3  in  4 each  guess digits 0..3.
- write_frame  in  1  level request from the solver: a guess is present.
- frame_written  out  1  acknowledge; results are valid while it is high.
- bulls  out  3  bulls of the last scored guess (0..4).
- cows  out  3  cows of the last scored guess (0..4); bulls+cows ≤ 4.
- attempts  out  8  guesses scored since the last load; saturates at 255.
- secret_valid  out  1  a secret has been loaded.
- win  out  1  the last scored guess had bulls==4.
- game_over  out  1  win, or the attempt limit has been reached.

## Operation
- States: IDLE, BULL, COW, ACK. Internal registers: latched guess g[0..3], secret s[0..3], index i (2 bit), bull mask bm[3:0], used mask um[3:0], bull_cnt, cow_cnt.
- IDLE, `load`=1: do the following and stay in IDLE.
  - capture s; set secret_valid=1.
  - clear attempts, bulls, cows, win and game_over.
- `load` outside IDLE is ignored.
- IDLE, `write_frame`=1 and secret_valid=1 and game_over=0:
  - latch g from guessed_number_0..3;
  - clear i, bm, um, bull_cnt, cow_cnt;
  - go to BULL.
- IDLE, `write_frame`=1 and secret_valid=0: ignored. frame_written stays 0.
- IDLE, `write_frame`=1 and game_over=1: go to ACK with no update to bulls, cows or attempts. The solver must never stall.
- `load` and `write_frame` high together in IDLE: `load` wins and the request is re-evaluated next cycle.
- BULL, one digit per cycle:
  - if g[i]==s[i], set bm[i] and increment bull_cnt.
  - i increments; after i=3, reset i to 0 and go to COW.
- COW, one digit per cycle:
  - if bm[i]=0, find the lowest j with bm[j]=0, um[j]=0 and s[j]==g[i];
  - if such a j exists, set um[j] and increment cow_cnt.
  - after i=3, go to ACK. On this same edge:
    - commit bulls=bull_cnt and cows=final cow_cnt;
    - attempts+1 (saturating at 255); win=(bull_cnt==4);
    - game_over=win | (MAX_ATTEMPTS≠0 & new attempts==MAX_ATTEMPTS).
- ACK: frame_written=1. When `write_frame` is sampled 0, clear frame_written and go to IDLE.
- bulls, cows, win and attempts hold their values until the next commit, load or reset.
- Guess inputs are sampled only on the IDLE→BULL edge. Later changes do not affect the current score.

## Timing
- Reset values: all outputs 0, state IDLE, secret cleared, secret_valid=0.
- Reset mid-operation (any state) aborts the score with no partial commit. frame_written drops on the next edge.
- Latency: `write_frame` is sampled high in IDLE at edge N. Guess latched at N; bull pass on edges N+1..N+4; cow pass on edges N+5..N+8.
  - frame_written, bulls, cows, attempts, win and game_over all change on edge N+8.
- A game_over request gets frame_written on edge N+1.
- Handshake: frame_written stays high until `write_frame` is sampled low.
  - With the solver, which drops `write_frame` one cycle after seeing the ack, frame_written is high for exactly 2 cycles.
  - The next request can be accepted at the earliest one cycle after returning to IDLE.
- bulls is stable from edge N+8 until the next commit. This covers the solver's compare, which happens 3 cycles after the ack.
- Widths: bull_cnt and cow_cnt are 3 bit and cannot exceed 4. attempts saturates at 255 with no wrap.

## Test plan
- Exact match:
  - Stimulus: load 1,2,3,4, then guess 1,2,3,4.
  - Required: frame_written rises 8 cycles after `write_frame` is sampled; bulls=4, cows=0, win=1, game_over=1, attempts=1.
  - Then a second request is acked on the next edge and bulls stays 4.
- Full permutation: secret 1,2,3,4, guess 4,3,2,1 → bulls=0, cows=4. Then guess 1,2,4,3 → bulls=2, cows=2, attempts=2.
- Duplicates:
  - secret 1,1,2,3, guess 1,1,1,1 → bulls=2, cows=0.
  - guess 2,1,1,0 → bulls=1, cows=2.
  - secret 0,0,0,0, guess 0,5,5,5 → bulls=1, cows=0.
- Handshake and gating:
  - `write_frame` before any load → frame_written stays 0 for 20 cycles.
  - After load, a 2-cycle ack, then IDLE.
  - Holding `write_frame` high keeps frame_written high.
  - Guess inputs changed during BULL do not alter the result.
- Attempt limit and load: MAX_ATTEMPTS=3 with 3 wrong guesses → game_over=1, win=0, attempts=3. Then `load` clears attempts, win and game_over.
- Reset mid-score: assert rst at edge N+5 → all outputs 0 next cycle and no commit. Then load plus a guess scores correctly.
- Closed loop with the solver: the solver reaches done=1, with the final guess equal to the secret and bulls=4.
